// File: rtl/panel_tx_pkg.sv
// Shared state encoding, default parameters and a counter-width helper
// for the panel serial transmitter.
package panel_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STALL = 3'd3,
    ST_LATCH = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CHAIN_LEN = 8;
  localparam int DEF_CLK_DIV   = 4;

  // Counter width for a 0..v-1 range, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/panel_tx_tick.sv
// Half-period strobe: tick is high on every CLK_DIV-th cycle; clear
// restarts the count so the next tick lands CLK_DIV cycles later.
module panel_tx_tick
  import panel_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + DW'(1);
    if (clear || tick) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

endmodule

// File: rtl/panel_serial_tx.sv
// Stream-to-serial driver for a daisy-chained LED shift-register chain.
// Define PANEL_TX_BLANK_EN to blank oe_n across each latch and gap.
module panel_serial_tx
  import panel_tx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sdo,
  output logic              sclk,
  output logic              slat,
  output logic              oe_n,
  output logic              busy,
  output logic              stall,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W);
  localparam int WW = cnt_w(CHAIN_LEN);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(CHAIN_LEN - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              hold_full_q, hold_full_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WW-1:0]     word_q, word_d;
  logic              phase_q, phase_d;
  logic              tick, tick_clear, accept, load;

  panel_tx_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign s_ready = !hold_full_q && !rst;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    word_d     = word_q;
    phase_d    = phase_q;
    load       = 1'b0;
    tick_clear = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_STALL: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tick_clear = 1'b1;
        phase_d    = 1'b0;
        bit_d      = BIT_LAST;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        // phase_q low = sclk low half, high = sclk high half of a bit
        if (tick) begin
          phase_d = !phase_q;
          if (phase_q) begin
            if (bit_q != '0) begin
              bit_d   = bit_q - BW'(1);
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end else if (word_q == WORD_LAST) begin
              word_d     = '0;
              tick_clear = 1'b1;
              state_d    = ST_LATCH;
            end else begin
              word_d = word_q + WW'(1);
              if (hold_full_q) begin
                load  = 1'b1;
                bit_d = BIT_LAST;
              end else begin
                state_d = ST_STALL;
              end
            end
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          phase_d = !phase_q;
          if (phase_q) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) shreg_d = hold_q;
    hold_full_d = (hold_full_q && !load) || accept;
    hold_d      = accept ? s_data : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      shreg_q     <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      word_q      <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shreg_q     <= shreg_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      phase_q     <= phase_d;
    end
  end

  assign sclk  = (state_q == ST_SHIFT) && phase_q;
  assign slat  = (state_q == ST_LATCH);
  assign sdo   = ((state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_STALL))
                 ? shreg_q[DATA_W-1] : 1'b0;
  assign busy  = (state_q != ST_IDLE) || hold_full_q;
  assign stall = (state_q == ST_STALL);

`ifdef PANEL_TX_BLANK_EN
  // Outputs stay dark until the chain has been latched once after reset.
  logic latched_q, latched_d;

  always_comb begin
    latched_d = latched_q || frame_done;
  end

  always_ff @(posedge clk) begin
    if (rst) latched_q <= 1'b0;
    else     latched_q <= latched_d;
  end

  assign oe_n = !latched_q || (state_q == ST_LATCH) || (state_q == ST_GAP);
`else
  assign oe_n = 1'b0;
`endif

endmodule

// File: tb/tb_panel_serial_tx.sv
// Scoreboard bench for panel_serial_tx: expected bits queued at accept,
// a negedge monitor checks serial output, latch framing and timing.
module tb_panel_serial_tx;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int C  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, sdo, sclk, slat, oe_n, busy, stall, frame_done;

  panel_serial_tx #(.DATA_W(DW), .CHAIN_LEN(N), .CLK_DIV(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .sdo        (sdo),
    .sclk       (sclk),
    .slat       (slat),
    .oe_n       (oe_n),
    .busy       (busy),
    .stall      (stall),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state: the bit stream the chain must see, MSB first.
  logic   exp_bits[$];
  logic   last_bit = 1'b0;
  logic [31:0] cap = '0;
  int     cyc = 0, total_rises = 0, frames = 0;
  int     bits_since_latch = 0, slat_len = 0, last_slat_cyc = 0;
  int     first_rise_cyc = 0, busy_rise_cyc = 0;
  bit     frame_started = 0, stalled_frame = 0, busy_rise_valid = 0;
  bit     gap_active = 0, frame_seen = 0;
  logic   prev_sclk = 0, prev_slat = 0, prev_busy = 0;
  logic   exp_oe;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_bits.delete();
      bits_since_latch = 0;
      slat_len         = 0;
      gap_active       = 0;
      frame_seen       = 0;
      frame_started    = 0;
      stalled_frame    = 0;
      busy_rise_valid  = 0;
    end else begin
      if (busy && !prev_busy) begin
        busy_rise_cyc   = cyc;
        busy_rise_valid = 1;
      end
      if (sclk && !prev_sclk) begin
        total_rises++;
        bits_since_latch++;
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL extra_sclk: actual=rise with no pending bit required=no rise (cycle %0d)", cyc);
        end else begin
          last_bit = exp_bits.pop_front();
          chk("sdo_bit", sdo, last_bit);
        end
        cap = {cap[30:0], sdo};
        if (!frame_started) begin
          frame_started  = 1;
          first_rise_cyc = cyc;
          if (busy_rise_valid) chk("first_rise_latency", cyc - busy_rise_cyc, C + 2);
        end
        busy_rise_valid = 0;
      end else if (sclk && prev_sclk) begin
        chk("sdo_stable_high", sdo, last_bit);
      end
      if (stall) begin
        stalled_frame = 1;
        chk("stall_sclk", sclk, 0);
        chk("stall_sdo", sdo, last_bit);
      end
      if (slat) begin
        chk("slat_sclk", sclk, 0);
        if (!prev_slat) begin
          chk("bits_per_latch", bits_since_latch, N * DW);
          bits_since_latch = 0;
        end
        slat_len++;
      end else if (prev_slat) begin
        chk("slat_len", slat_len, 2 * C);
        slat_len      = 0;
        gap_active    = 1;
        last_slat_cyc = cyc - 1;
      end
`ifdef PANEL_TX_BLANK_EN
      exp_oe = slat || gap_active || !frame_seen;
`else
      exp_oe = 1'b0;
`endif
      chk("oe_n", oe_n, exp_oe);
      if (frame_done) begin
        chk("gap_len", cyc - last_slat_cyc, C);
        if (!stalled_frame)
          chk("frame_duration", cyc - first_rise_cyc, N * DW * 2 * C + 2 * C - 1);
        frames++;
        frame_started = 0;
        stalled_frame = 0;
        gap_active    = 0;
        frame_seen    = 1;
      end
    end
    prev_sclk = sclk;
    prev_slat = slat;
    prev_busy = busy;
  end

  task automatic send_word(input logic [DW-1:0] w);
    int budget;
    budget  = 0;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && budget < 3000) begin
      budget++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=no s_ready required=accept of %0h", w);
    end else begin
      for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(w[i]);
      $display("send word=%04h at cycle %0d", w, cyc);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((busy || exp_bits.size() != 0) && budget < 20000) begin
      budget++;
      @(negedge clk);
    end
    chk("drain_pending_bits", exp_bits.size(), 0);
    chk("drain_busy", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int f0;
  int target;
  int budget;

  initial begin
    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sdo", sdo, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_slat", slat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_s_ready", s_ready, 0);
`ifdef PANEL_TX_BLANK_EN
    chk("rst_oe_n", oe_n, 1);
`else
    chk("rst_oe_n", oe_n, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    wait_cycles(2);

    // Back-to-back chain
    f0  = frames;
    cap = '0;
    send_word(16'hA5C3);
    send_word(16'h0F0F);
    wait_idle();
    chk("b2b_capture", cap, 32'hA5C30F0F);
    chk("b2b_frames", frames - f0, 1);
    $display("back_to_back frames=%0d capture=%08h", frames - f0, cap);
    wait_cycles(1);

    // Underrun: second word withheld for 200 cycles
    f0 = frames;
    send_word(16'hA5C3);
    repeat (150) @(negedge clk);
    chk("underrun_stall", stall, 1);
    chk("underrun_sdo", sdo, 1);
    chk("underrun_sclk", sclk, 0);
    wait_cycles(50);
    send_word(16'h0F0F);
    wait_idle();
    chk("underrun_capture", cap, 32'hA5C30F0F);
    chk("underrun_frames", frames - f0, 1);
    $display("underrun frames=%0d capture=%08h", frames - f0, cap);
    wait_cycles(1);

    // Backpressure: four words with s_valid held high
    f0 = frames;
    send_word(16'h1357);
    send_word(16'h2468);
    send_word(16'hFFFF);
    send_word(16'h8001);
    wait_idle();
    chk("backpressure_frames", frames - f0, 2);
    chk("backpressure_capture", cap, 32'hFFFF8001);
    $display("backpressure frames=%0d", frames - f0);
    wait_cycles(1);

    // Reset during the first word
    f0 = frames;
    send_word(16'hC0DE);
    target = total_rises + 5;
    budget = 0;
    while (total_rises < target && budget < 1000) begin
      budget++;
      @(posedge clk);
    end
    chk("midrst_reached_bit5", total_rises >= target, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_sdo", sdo, 0);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_slat", slat, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    wait_cycles(10);
    chk("midrst_no_latch", frames - f0, 0);
    send_word(16'h1234);
    send_word(16'h5678);
    wait_idle();
    chk("midrst_capture", cap, 32'h12345678);
    chk("midrst_frames", frames - f0, 1);
    $display("midreset frames=%0d capture=%08h", frames - f0, cap);
    wait_cycles(1);

    // Randomized words with random gaps (some underruns)
    f0 = frames;
    for (int i = 0; i < 24; i++) begin
      send_word(16'($urandom));
      wait_cycles($urandom_range(0, 90));
    end
    wait_idle();
    chk("random_frames", frames - f0, 12);
    $display("random frames=%0d", frames - f0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
